// File: rtl/dram_pkg.sv
// Shared types and default timing for the single-bank DRAM model.
// Holds the bank states, the command set and the command decoder.
package dram_pkg;

  localparam int DEF_ROW_BITS = 11;
  localparam int DEF_COL_BITS = 10;
  localparam int DEF_T_RCD    = 5;
  localparam int DEF_T_RP     = 5;
  localparam int DEF_CAS_LAT  = 5;

  typedef enum logic [1:0] {
    CLOSED,
    ACTIVATING,
    OPEN,
    PRECHARGING
  } bank_e;

  typedef enum logic [2:0] {
    ACT,
    PRE,
    RD,
    WR,
    NOP,
    ILL
  } cmd_e;

  // A deselected chip decodes as NOP.
  function automatic cmd_e decode(
    input logic       csn,
    input logic       rasn,
    input logic       casn,
    input logic [3:0] wen
  );
    cmd_e c;
    c = ILL;
    if (csn)
      c = NOP;
    else if (!rasn && casn && wen == 4'hF)
      c = ACT;
    else if (!rasn && casn && wen == 4'h0)
      c = PRE;
    else if (rasn && !casn && wen == 4'hF)
      c = RD;
    else if (rasn && !casn)
      c = WR;
    else if (rasn && casn)
      c = NOP;
    return c;
  endfunction

endpackage

// File: rtl/dram_rd_pipe.sv
// Read-latency shift register: valid bit plus data word per stage.
// Each stage's data only moves with a valid, so the output holds.
module dram_rd_pipe #(
  parameter int DEPTH = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  output logic        valid,
  output logic [31:0] q
);

  logic [DEPTH-1:0] v;
  logic [31:0]      d [DEPTH];

  // Shift valid every cycle; data stages load only behind a valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      v <= '0;
      for (int i = 0; i < DEPTH; i++)
        d[i] <= '0;
    end else begin
      v[0] <= in_valid;
      if (in_valid)
        d[0] <= in_data;
      for (int i = 1; i < DEPTH; i++) begin
        v[i] <= v[i-1];
        if (v[i-1])
          d[i] <= d[i-1];
      end
    end
  end

  assign valid = v[DEPTH-1];
  assign q     = d[DEPTH-1];

endmodule

// File: rtl/dram_model.sv
// Single-bank DRAM behavioural model: command decode, bank FSM,
// byte-masked word array and a fixed CAS-latency read return.
module dram_model
  import dram_pkg::*;
#(
  parameter int ROW_BITS = DEF_ROW_BITS,
  parameter int COL_BITS = DEF_COL_BITS,
  parameter int T_RCD    = DEF_T_RCD,
  parameter int T_RP     = DEF_T_RP,
  parameter int CAS_LAT  = DEF_CAS_LAT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        CSn,
  input  logic        RASn,
  input  logic        CASn,
  input  logic [3:0]  WEn,
  input  logic [10:0] A,
  input  logic [31:0] D,
  output logic [31:0] Q,
  output logic        VALID,
  output logic        CMD_ERR
);

  localparam int AW     = ROW_BITS + COL_BITS;
  localparam int MAXT   = (T_RCD > T_RP) ? T_RCD : T_RP;
  localparam int CW     = $clog2(MAXT) + 1;
  localparam int RCD_LD = (T_RCD > 2) ? T_RCD - 2 : 0;
  localparam int RP_LD  = (T_RP > 2) ? T_RP - 2 : 0;

  logic [31:0]         mem [2**AW];
  bank_e               state;
  logic [ROW_BITS-1:0] row;
  logic [CW-1:0]       cnt;
  cmd_e                cmd;
  logic                legal;
  logic                acc_rd;
  logic                acc_wr;
  logic [AW-1:0]       idx;
  logic                rd_req;
  logic [31:0]         rd_word;

  // Decode the sampled command and judge it against the bank state.
  always_comb begin
    cmd   = decode(CSn, RASn, CASn, WEn);
    legal = 1'b0;
    unique case (cmd)
      ACT:     legal = (state == CLOSED);
      PRE:     legal = (state == OPEN);
      RD, WR:  legal = (state == OPEN);
      NOP:     legal = 1'b1;
      default: legal = 1'b0;
    endcase
    acc_rd = (cmd == RD) && (state == OPEN);
    acc_wr = (cmd == WR) && (state == OPEN);
    idx    = {row, A[COL_BITS-1:0]};
  end

  // Bank FSM; counters load on entry and stop at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= CLOSED;
      row     <= '0;
      cnt     <= '0;
      CMD_ERR <= 1'b0;
    end else begin
      CMD_ERR <= !legal;
      unique case (state)
        CLOSED:
          if (cmd == ACT) begin
            state <= ACTIVATING;
            row   <= A[ROW_BITS-1:0];
            cnt   <= CW'(RCD_LD);
          end
        ACTIVATING:
          if (cnt == '0)
            state <= OPEN;
          else
            cnt <= cnt - CW'(1);
        OPEN:
          if (cmd == PRE) begin
            state <= PRECHARGING;
            cnt   <= CW'(RP_LD);
          end
        PRECHARGING:
          if (cnt == '0)
            state <= CLOSED;
          else
            cnt <= cnt - CW'(1);
        default:
          state <= CLOSED;
      endcase
    end
  end

  // Byte-masked write; the array is never cleared by reset.
  always_ff @(posedge clk) begin
    if (!rst && acc_wr) begin
      for (int i = 0; i < 4; i++)
        if (!WEn[i])
          mem[idx][8*i +: 8] <= D[8*i +: 8];
    end
  end

  // Capture the read word in the cycle the RD is sampled.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_req  <= 1'b0;
      rd_word <= '0;
    end else begin
      rd_req <= acc_rd;
      if (acc_rd)
        rd_word <= mem[idx];
    end
  end

  dram_rd_pipe #(
    .DEPTH (CAS_LAT)
  ) u_rd_pipe (
    .clk      (clk),
    .rst      (rst),
    .in_valid (rd_req),
    .in_data  (rd_word),
    .valid    (VALID),
    .q        (Q)
  );

endmodule

// File: tb/tb_dram_model.sv
// Directed bench for dram_model with default timing (5/5/5).
// Inputs change #1 after a rising edge; outputs are checked there too.
module tb_dram_model;
  import dram_pkg::*;

  logic        clk;
  logic        rst;
  logic        CSn;
  logic        RASn;
  logic        CASn;
  logic [3:0]  WEn;
  logic [10:0] A;
  logic [31:0] D;
  logic [31:0] Q;
  logic        VALID;
  logic        CMD_ERR;

  int errors = 0;
  int checks = 0;

  dram_model dut (
    .clk     (clk),
    .rst     (rst),
    .CSn     (CSn),
    .RASn    (RASn),
    .CASn    (CASn),
    .WEn     (WEn),
    .A       (A),
    .D       (D),
    .Q       (Q),
    .VALID   (VALID),
    .CMD_ERR (CMD_ERR)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_nop();
    CSn = 1'b0; RASn = 1'b1; CASn = 1'b1;
    WEn = 4'hF; A = '0; D = '0;
  endtask

  task automatic issue(input logic csn, input logic rasn,
                       input logic casn, input logic [3:0] wen,
                       input logic [10:0] a, input logic [31:0] d);
    CSn = csn; RASn = rasn; CASn = casn;
    WEn = wen; A = a; D = d;
    tick();
    set_nop();
  endtask

  task automatic nops(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic act(input logic [10:0] r);
    issue(1'b0, 1'b0, 1'b1, 4'hF, r, '0);
  endtask

  task automatic pre();
    issue(1'b0, 1'b0, 1'b1, 4'h0, '0, '0);
  endtask

  task automatic rd(input logic [10:0] c);
    issue(1'b0, 1'b1, 1'b0, 4'hF, c, '0);
  endtask

  task automatic wr(input logic [10:0] c, input logic [3:0] wen,
                    input logic [31:0] d);
    issue(1'b0, 1'b1, 1'b0, wen, c, d);
  endtask

  // Called right after a RD tick: 4 quiet cycles, then the data.
  task automatic wait_rd(input string tag, input logic [31:0] exp);
    for (int i = 1; i < 5; i++) begin
      tick();
      chk({tag, "_early"}, 32'(VALID), 32'd0);
    end
    tick();
    chk({tag, "_valid"}, 32'(VALID), 32'd1);
    chk({tag, "_q"}, Q, exp);
  endtask

  initial begin
    set_nop();
    rst = 1'b1;
    nops(2);
    chk("rst_valid", 32'(VALID), 32'd0);
    chk("rst_q", Q, 32'h0);
    chk("rst_err", 32'(CMD_ERR), 32'd0);
    chk("rst_state", 32'(dut.state), 32'(CLOSED));
    rst = 1'b0;

    // Open row 3 and time the activate window.
    act(11'd3);
    chk("act_state", 32'(dut.state), 32'(ACTIVATING));
    chk("act_err", 32'(CMD_ERR), 32'd0);
    nops(3);
    chk("act_hold", 32'(dut.state), 32'(ACTIVATING));
    nops(1);
    chk("act_open", 32'(dut.state), 32'(OPEN));

    wr(11'd5, 4'h0, 32'hDEADBEEF);
    pre();
    chk("pre_state", 32'(dut.state), 32'(PRECHARGING));
    nops(3);
    chk("pre_hold", 32'(dut.state), 32'(PRECHARGING));
    nops(1);
    chk("pre_closed", 32'(dut.state), 32'(CLOSED));

    act(11'd3);
    nops(4);
    rd(11'd5);
    wait_rd("rd1", 32'hDEADBEEF);
    tick();
    chk("hold_valid", 32'(VALID), 32'd0);
    chk("hold_q", Q, 32'hDEADBEEF);

    // Byte mask write, read next cycle, column high bit ignored.
    wr(11'h405, 4'b1010, 32'h11223344);
    rd(11'h005);
    wait_rd("mask", 32'hDE22BE44);

    // Back-to-back reads of cols 0..3.
    for (int i = 0; i < 4; i++)
      wr(11'(i), 4'h0, 32'hA0 + 32'(i));
    for (int i = 0; i < 4; i++)
      rd(11'(i));
    nops(2);
    chk("b2b0_v", 32'(VALID), 32'd1);
    chk("b2b0_q", Q, 32'hA0);
    tick();
    chk("b2b1_v", 32'(VALID), 32'd1);
    chk("b2b1_q", Q, 32'hA1);
    tick();
    chk("b2b2_v", 32'(VALID), 32'd1);
    chk("b2b2_q", Q, 32'hA2);
    tick();
    chk("b2b3_v", 32'(VALID), 32'd1);
    chk("b2b3_q", Q, 32'hA3);
    tick();
    chk("b2b_end", 32'(VALID), 32'd0);

    // Illegal commands in OPEN: ACT and an undefined pattern.
    act(11'd9);
    chk("actopen_err", 32'(CMD_ERR), 32'd1);
    chk("actopen_st", 32'(dut.state), 32'(OPEN));
    issue(1'b0, 1'b0, 1'b0, 4'hF, '0, '0);
    chk("undef_err", 32'(CMD_ERR), 32'd1);
    tick();
    chk("undef_clr", 32'(CMD_ERR), 32'd0);

    // Deselected chip with RAS/CAS low decodes to nothing.
    issue(1'b1, 1'b0, 1'b0, 4'h0, '0, '0);
    chk("csn_err", 32'(CMD_ERR), 32'd0);
    chk("csn_state", 32'(dut.state), 32'(OPEN));

    // RD on second cycle after ACT is rejected.
    pre();
    nops(4);
    chk("re_closed", 32'(dut.state), 32'(CLOSED));
    act(11'd7);
    nops(1);
    rd(11'd1);
    chk("early_err", 32'(CMD_ERR), 32'd1);
    chk("early_st", 32'(dut.state), 32'(ACTIVATING));
    tick();
    chk("early_pulse", 32'(CMD_ERR), 32'd0);
    tick();
    chk("early_open", 32'(dut.state), 32'(OPEN));
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("early_novld", 32'(VALID), 32'd0);
    end

    // Reset two cycles after a RD flushes it.
    pre();
    nops(4);
    act(11'd3);
    nops(4);
    rd(11'd5);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_valid", 32'(VALID), 32'd0);
    chk("mid_q", Q, 32'h0);
    chk("mid_state", 32'(dut.state), 32'(CLOSED));
    act(11'd3);
    chk("post_act", 32'(dut.state), 32'(ACTIVATING));
    for (int i = 0; i < 4; i++) begin
      chk("post_novld", 32'(VALID), 32'd0);
      tick();
    end
    chk("post_open", 32'(dut.state), 32'(OPEN));
    rd(11'd5);
    wait_rd("survive", 32'hDE22BE44);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
